tri_normal_pair_cull: RTL and testbench

- Downstream consumer of the triangle surface-normal stage.
- That stage has a fixed multi-cycle float latency and no backpressure. This block stores each triangle issued to it in an in-order queue and pairs the triangle with its normal when `normal_valid` pulses.
- Culls back-facing and degenerate triangles using only sign, exponent and mantissa bit tests on the f16 normal (no float IP).
- Delivers {triangle, normal} pairs to the rasteriser through a valid/ready output queue.

---
 rtl/tri_normal_pair_cull.sv | 136 +++++++++++++
 tb/tb_tri_normal_pair_cull.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/tri_normal_pair_cull.sv
// tri_normal_pair_cull: pairs queued triangles with their normals, culls back-facing/degenerate/NaN, queues pairs out
module tri_normal_pair_cull #(
    parameter int TRI_DEPTH = 16,
    parameter int OUT_DEPTH = 4,
    parameter bit CULL_EN   = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tri_valid,
    input  logic [143:0] triangle,
    output logic         tri_ready,
    input  logic         normal_valid,
    input  logic [47:0]  normal,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [143:0] out_triangle,
    output logic [47:0]  out_normal,
    output logic [15:0]  culled_count,
    output logic         overflow,
    output logic         underflow
);
    localparam int TW = $clog2(TRI_DEPTH);
    localparam int OW = $clog2(OUT_DEPTH);

    logic [143:0] r_tri_mem [TRI_DEPTH];
    logic [TW-1:0] r_tri_wr, r_tri_rd;
    logic [TW:0]   r_tri_cnt;
    logic          r_tri_ready;
    logic [191:0]  r_out_mem [OUT_DEPTH];
    logic [OW-1:0] r_out_wr, r_out_rd;
    logic [OW:0]   r_out_cnt;
    logic          r_pair_valid, r_pair_cull;
    logic [191:0]  r_pair;
    logic [15:0]   r_culled;
    logic          r_overflow, r_underflow;

    logic          w_tri_empty, w_tri_full, w_tri_pop, w_tri_push, w_tri_drop;
    logic [TW:0]   w_tri_cnt_nxt;
    logic          w_out_full, w_out_pop, w_out_push, w_out_drop;
    logic [15:0]   w_nx, w_ny, w_nz;
    logic          w_back, w_degen, w_nan, w_cull;

    assign w_tri_empty   = r_tri_cnt == '0;
    assign w_tri_full    = r_tri_cnt == (TW+1)'(TRI_DEPTH);
    assign w_tri_pop     = normal_valid && !w_tri_empty;
    assign w_tri_push    = tri_valid && (!w_tri_full || w_tri_pop);
    assign w_tri_drop    = tri_valid && w_tri_full && !w_tri_pop;
    assign w_tri_cnt_nxt = r_tri_cnt + (TW+1)'(w_tri_push) - (TW+1)'(w_tri_pop);

    assign w_out_full = r_out_cnt == (OW+1)'(OUT_DEPTH);
    assign out_valid  = r_out_cnt != '0;
    assign w_out_pop  = out_valid && out_ready;
    assign w_out_push = r_pair_valid && !r_pair_cull && (!w_out_full || w_out_pop);
    assign w_out_drop = r_pair_valid && !r_pair_cull && w_out_full && !w_out_pop;

    assign w_nx = normal[15:0];
    assign w_ny = normal[31:16];
    assign w_nz = normal[47:32];

    // Cull decision from f16 bit fields: negative nonzero z, all-zero magnitude, or any NaN
    always_comb begin
        w_back  = w_nz[15] && (w_nz[14:0] != 15'd0);
        w_degen = ~|{w_nx[14:0], w_ny[14:0], w_nz[14:0]};
        w_nan   = (&w_nx[14:10] && |w_nx[9:0]) || (&w_ny[14:10] && |w_ny[9:0]) || (&w_nz[14:10] && |w_nz[9:0]);
        w_cull  = CULL_EN && (w_back || w_degen || w_nan);
    end

    assign tri_ready    = r_tri_ready;
    assign out_triangle = out_valid ? r_out_mem[r_out_rd][191:48] : 144'd0;
    assign out_normal   = out_valid ? r_out_mem[r_out_rd][47:0] : 48'd0;
    assign culled_count = r_culled;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    // Queue storage needs no reset; occupancy counters gate every read
    always_ff @(posedge clk) begin
        if (w_tri_push) r_tri_mem[r_tri_wr] <= triangle;
        if (w_out_push) r_out_mem[r_out_wr] <= r_pair;
    end

    // Triangle queue pointers, count and registered ready
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tri_wr    <= '0;
            r_tri_rd    <= '0;
            r_tri_cnt   <= '0;
            r_tri_ready <= 1'b1;
        end else begin
            if (w_tri_push) r_tri_wr <= r_tri_wr + TW'(1);
            if (w_tri_pop) r_tri_rd <= r_tri_rd + TW'(1);
            r_tri_cnt   <= w_tri_cnt_nxt;
            r_tri_ready <= w_tri_cnt_nxt != (TW+1)'(TRI_DEPTH);
        end
    end

    // Pair stage: head triangle joined with its normal and the cull verdict
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pair_valid <= 1'b0;
            r_pair_cull  <= 1'b0;
            r_pair       <= '0;
        end else begin
            r_pair_valid <= w_tri_pop;
            if (w_tri_pop) begin
                r_pair      <= {r_tri_mem[r_tri_rd], normal};
                r_pair_cull <= w_cull;
            end
        end
    end

    // Output queue pointers and count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_wr  <= '0;
            r_out_rd  <= '0;
            r_out_cnt <= '0;
        end else begin
            if (w_out_push) r_out_wr <= r_out_wr + OW'(1);
            if (w_out_pop) r_out_rd <= r_out_rd + OW'(1);
            r_out_cnt <= r_out_cnt + (OW+1)'(w_out_push) - (OW+1)'(w_out_pop);
        end
    end

    // Saturating cull counter and sticky error flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_culled    <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (r_pair_valid && r_pair_cull && r_culled != 16'hFFFF) r_culled <= r_culled + 16'd1;
            if (w_tri_drop || w_out_drop) r_overflow <= 1'b1;
            if (normal_valid && w_tri_empty) r_underflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_tri_normal_pair_cull.sv
// tb_tri_normal_pair_cull: scoreboard bench, one culling and one pass-through instance on shared stimulus
module tb_tri_normal_pair_cull;
    typedef logic [191:0] pair_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         tri_valid = 1'b0, normal_valid = 1'b0, out_ready = 1'b1;
    logic [143:0] triangle = '0;
    logic [47:0]  normal = '0;
    logic [1:0]   trdy, ov, ovf, unf;
    logic [143:0] ot [2];
    logic [47:0]  on [2];
    logic [15:0]  cc [2];

    int checks = 0, errors = 0;

    logic [143:0] mtri[$];
    bit           pv;
    pair_t        pdata;
    pair_t        sbq [2][$];
    int           occ [2];
    int           mcnt [2];
    bit           movf [2];
    bit           munf;

    logic [15:0] sp [8] = '{16'h0000, 16'h8000, 16'h7C00, 16'hFC00, 16'h7E00, 16'h7C01, 16'hBC00, 16'h3C00};

    always #5 clk = ~clk;

    tri_normal_pair_cull #(.TRI_DEPTH(16), .OUT_DEPTH(4), .CULL_EN(1'b1)) u_cull (
        .clk(clk), .rst(rst), .tri_valid(tri_valid), .triangle(triangle), .tri_ready(trdy[0]),
        .normal_valid(normal_valid), .normal(normal), .out_valid(ov[0]), .out_ready(out_ready),
        .out_triangle(ot[0]), .out_normal(on[0]), .culled_count(cc[0]), .overflow(ovf[0]), .underflow(unf[0]));

    tri_normal_pair_cull #(.TRI_DEPTH(16), .OUT_DEPTH(4), .CULL_EN(1'b0)) u_pass (
        .clk(clk), .rst(rst), .tri_valid(tri_valid), .triangle(triangle), .tri_ready(trdy[1]),
        .normal_valid(normal_valid), .normal(normal), .out_valid(ov[1]), .out_ready(out_ready),
        .out_triangle(ot[1]), .out_normal(on[1]), .culled_count(cc[1]), .overflow(ovf[1]), .underflow(unf[1]));

    task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit culls(input logic [47:0] n);
        logic [15:0] c;
        bit nan = 0, zero = 1, back;
        for (int i = 0; i < 3; i++) begin
            c = n[16*i +: 16];
            if (c[14:10] == 5'd31 && c[9:0] != 10'd0) nan = 1;
            if (c[14:0] != 15'd0) zero = 0;
        end
        back = n[47] && n[46:32] != 15'd0;
        return nan || zero || back;
    endfunction

    // Reference model: spec-level queues advanced once per clock edge
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mtri.delete();
            pv = 0;
            munf = 0;
            for (int c = 0; c < 2; c++) begin
                sbq[c].delete();
                occ[c] = 0;
                mcnt[c] = 0;
                movf[c] = 0;
            end
        end else begin
            int sz;
            bit popt, po;
            sz = mtri.size();
            popt = normal_valid && sz > 0;
            for (int c = 0; c < 2; c++) begin
                po = occ[c] > 0 && out_ready;
                if (pv) begin
                    if (c == 0 && culls(pdata[47:0])) begin
                        if (mcnt[c] < 65535) mcnt[c]++;
                    end else if (occ[c] < 4 || po) begin
                        sbq[c].push_back(pdata);
                        occ[c]++;
                    end else movf[c] = 1;
                end
                if (po) occ[c]--;
            end
            if (normal_valid && sz == 0) munf = 1;
            if (popt) pdata = {mtri.pop_front(), normal};
            pv = popt;
            if (tri_valid) begin
                if (sz < 16 || popt) mtri.push_back(triangle);
                else begin
                    movf[0] = 1;
                    movf[1] = 1;
                end
            end
        end
    end

    // Monitor: compares presented head and status against the model, pops on handshake
    always @(negedge clk) begin
        if (rst) begin
            for (int c = 0; c < 2; c++) begin
                chk("out_valid", 192'(ov[c]), 192'(occ[c] > 0));
                if (occ[c] > 0 && sbq[c].size() > 0) chk("out_pair", {ot[c], on[c]}, sbq[c][0]);
                else chk("out_pair_idle", {ot[c], on[c]}, '0);
                chk("tri_ready", 192'(trdy[c]), 192'(mtri.size() < 16));
                chk("overflow", 192'(ovf[c]), 192'(movf[c]));
                chk("underflow", 192'(unf[c]), 192'(munf));
                chk("culled_count", 192'(cc[c]), 192'(mcnt[c]));
                if (ov[c] && out_ready && sbq[c].size() > 0) void'(sbq[c].pop_front());
            end
        end
    end

    task automatic cyc(input bit tv, input bit nv, input logic [47:0] n);
        logic [159:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom};
        tri_valid = tv;
        triangle = tv ? t[143:0] : '0;
        normal_valid = nv;
        normal = n;
        @(posedge clk);
        #1;
        tri_valid = 0;
        normal_valid = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 0;
        idle(2);
        #2 rst = 1;
        idle(1);
    endtask

    function automatic logic [15:0] rh();
        return ($urandom % 2) ? sp[$urandom % 8] : 16'($urandom);
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        idle(2);
        chk("reset_out_valid", 192'(ov), 192'(0));
        chk("reset_tri_ready", 192'(trdy), 192'(3));
        chk("reset_flags", 192'({ovf, unf}), 192'(0));
        chk("reset_data", {ot[0], on[0]}, '0);
        do_reset();

        repeat (3) cyc(1, 0, 0);
        idle(5);
        cyc(0, 1, {16'h3C00, 32'h0});
        chk("latency_1edge", 192'(ov), 192'(0));
        cyc(0, 1, {16'h3C00, 32'h0});
        chk("latency_2edge", 192'(ov), 192'(3));
        cyc(0, 1, {16'h3C00, 32'h0});
        idle(5);
        chk("basic_culled", 192'(cc[0]), 192'(0));

        cyc(1, 0, 0); cyc(0, 1, {16'hBC00, 32'h0});
        cyc(1, 0, 0); cyc(0, 1, {16'h8000, 16'h0000, 16'h3C00});
        cyc(1, 0, 0); cyc(0, 1, {16'h0000, 16'h8000, 16'h0000});
        cyc(1, 0, 0); cyc(0, 1, {16'h3C00, 16'h0000, 16'h7E00});
        idle(5);
        chk("cull_count_en", 192'(cc[0]), 192'(3));
        chk("cull_count_dis", 192'(cc[1]), 192'(0));

        out_ready = 0;
        repeat (6) cyc(1, 0, 0);
        repeat (6) cyc(0, 1, {16'h3C00, 16'($urandom), 16'h3C00});
        idle(4);
        chk("bp_valid", 192'(ov), 192'(3));
        chk("bp_overflow", 192'(ovf), 192'(3));
        out_ready = 1;
        idle(8);
        chk("bp_drained", 192'(ov), 192'(0));

        do_reset();
        repeat (16) cyc(1, 0, 0);
        chk("full_ready", 192'(trdy), 192'(0));
        chk("full_no_ovf", 192'(ovf), 192'(0));
        cyc(1, 0, 0);
        chk("full_overflow", 192'(ovf), 192'(3));
        repeat (16) cyc(0, 1, {16'h3C00, 32'h0});
        idle(4);
        chk("full_unf_clear", 192'(unf), 192'(0));
        cyc(0, 1, {16'h3C00, 32'h0});
        idle(3);
        chk("underflow_set", 192'(unf), 192'(3));
        chk("underflow_no_out", 192'(ov), 192'(0));

        do_reset();
        for (int i = 0; i < 2500; i++) begin
            out_ready = ($urandom % 4) != 0;
            cyc(trdy[0] && ($urandom % 2), (mtri.size() > 0 && ($urandom % 3 == 0)) || ($urandom % 128 == 0),
                {rh(), rh(), rh()});
        end
        out_ready = 1;
        idle(10);

        do_reset();
        out_ready = 0;
        repeat (5) cyc(1, 0, 0);
        cyc(0, 1, {16'h3C00, 32'h0});
        cyc(0, 1, {16'hBC00, 32'h0});
        idle(3);
        chk("mid_pre_valid", 192'(ov), 192'(3));
        #2 rst = 0;
        #1;
        chk("mid_out_valid", 192'(ov), 192'(0));
        chk("mid_flags", 192'({ovf, unf}), 192'(0));
        chk("mid_count", 192'(cc[0]), 192'(0));
        chk("mid_tri_ready", 192'(trdy), 192'(3));
        chk("mid_data", {ot[0], on[0]}, '0);
        #2 rst = 1;
        out_ready = 1;
        idle(1);
        cyc(0, 1, {16'h3C00, 32'h0});
        idle(3);
        chk("mid_underflow", 192'(unf), 192'(3));
        chk("mid_no_out", 192'(ov), 192'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
